// File: rtl/vga_plot_sched.sv
// ============================================================================
// Module   : vga_plot_sched
// Purpose  : Pixel-write scheduler in front of the memory-mapped VGA plot
//            slave. Round-robin arbitration between two pixel requesters,
//            out-of-range pixel dropping with a saturating drop counter, an
//            optional full-screen clear engine, and a one-entry output
//            register that issues one Avalon-MM write per pixel.
// Ports    : clk, reset (async, active-high)
//            reqN_valid/ready/x/y/colour  - requester N pixel handshake (N=0,1)
//            clear_start/clear_colour     - fill-screen request and colour
//            clear_busy/clear_done        - clear engine status / done pulse
//            avm_address/write/writedata  - Avalon-MM master write port
//            avm_waitrequest              - slave stall
//            drop_count                   - rejected out-of-range pixels
// Config   : define VGA_SCHED_CLEAR_EN to build in the clear engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_plot_sched #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int DROP_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [7:0]        req0_x,
   input  logic [6:0]        req0_y,
   input  logic [7:0]        req0_colour,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [7:0]        req1_x,
   input  logic [6:0]        req1_y,
   input  logic [7:0]        req1_colour,
   input  logic              clear_start,
   input  logic [7:0]        clear_colour,
   output logic              clear_busy,
   output logic              clear_done,
   output logic [3:0]        avm_address,
   output logic              avm_write,
   output logic [31:0]       avm_writedata,
   input  logic              avm_waitrequest,
   output logic [DROP_W-1:0] drop_count
);

   localparam logic [7:0] c_X_LIMIT = 8'(SCREEN_W);
   localparam logic [6:0] c_Y_LIMIT = 7'(SCREEN_H);

   logic              r_or_valid;
   logic [31:0]       r_or_data;
   logic              r_last;
   logic [DROP_W-1:0] r_drop;

   logic        w_or_free;
   logic        w_block;
   logic        w_clr_load;
   logic [31:0] w_clr_data;
   logic        w_gnt0;
   logic        w_gnt1;
   logic        w_gnt;
   logic [7:0]  w_sel_x;
   logic [6:0]  w_sel_y;
   logic [7:0]  w_sel_col;
   logic        w_in_range;
   logic        w_req_load;
   logic        w_drop;
   logic        w_load;
   logic [31:0] w_load_data;

   // The output register can take a new word if empty or emptying this cycle.
   assign w_or_free = !r_or_valid || !avm_waitrequest;

   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!w_block && w_or_free) begin
         if (req0_valid && req1_valid) begin
            // Contention: grant whichever port did not win last time.
            w_gnt0 = r_last;
            w_gnt1 = !r_last;
         end else begin
            w_gnt0 = req0_valid;
            w_gnt1 = req1_valid;
         end
      end
   end

   assign w_gnt      = w_gnt0 || w_gnt1;
   assign w_sel_x    = w_gnt1 ? req1_x      : req0_x;
   assign w_sel_y    = w_gnt1 ? req1_y      : req0_y;
   assign w_sel_col  = w_gnt1 ? req1_colour : req0_colour;
   assign w_in_range = (w_sel_x < c_X_LIMIT) && (w_sel_y < c_Y_LIMIT);
   assign w_req_load = w_gnt && w_in_range;
   assign w_drop     = w_gnt && !w_in_range;

   assign w_load      = w_clr_load || w_req_load;
   assign w_load_data = w_clr_load ? w_clr_data
                                   : {1'b0, w_sel_y, w_sel_x, 8'h00, w_sel_col};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_or_valid <= 1'b0;
         r_or_data  <= 32'h0;
         r_last     <= 1'b1;
         r_drop     <= '0;
      end else begin
         if (w_load) begin
            r_or_valid <= 1'b1;
            r_or_data  <= w_load_data;
         end else if (r_or_valid && !avm_waitrequest) begin
            r_or_valid <= 1'b0;
         end
         if (w_gnt) begin
            r_last <= w_gnt1;
         end
         if (w_drop && (r_drop != '1)) begin
            r_drop <= r_drop + 1'b1;
         end
      end
   end

`ifdef VGA_SCHED_CLEAR_EN
   localparam logic [7:0] c_X_MAX = 8'(SCREEN_W - 1);
   localparam logic [6:0] c_Y_MAX = 7'(SCREEN_H - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_DRAIN = 2'd2
   } clr_state_t;

   clr_state_t r_state;
   clr_state_t w_state_nxt;
   logic [7:0] r_cx;
   logic [6:0] r_cy;
   logic [7:0] r_ccol;
   logic       w_clr_last;
   logic       w_done;

   assign w_clr_last = (r_cx == c_X_MAX) && (r_cy == c_Y_MAX);
   assign w_clr_data = {1'b0, r_cy, r_cx, 8'h00, r_ccol};

   always_comb begin
      w_state_nxt = r_state;
      w_clr_load  = 1'b0;
      w_block     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A clear arriving with a requester valid takes the cycle.
            w_block = clear_start;
            if (clear_start) begin
               w_state_nxt = S_FILL;
            end
         end
         S_FILL: begin
            w_block = 1'b1;
            if (w_or_free) begin
               w_clr_load = 1'b1;
               if (w_clr_last) begin
                  w_state_nxt = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            w_block = 1'b1;
            if (!r_or_valid) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cx    <= 8'h0;
         r_cy    <= 7'h0;
         r_ccol  <= 8'h0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == S_IDLE) && clear_start) begin
            r_cx   <= 8'h0;
            r_cy   <= 7'h0;
            r_ccol <= clear_colour;
         end else if (w_clr_load) begin
            if (r_cx == c_X_MAX) begin
               r_cx <= 8'h0;
               r_cy <= r_cy + 7'd1;
            end else begin
               r_cx <= r_cx + 8'd1;
            end
         end
      end
   end

   assign clear_busy = (r_state != S_IDLE);
   assign clear_done = w_done;
`else
   logic w_unused_clear;
   assign w_unused_clear = ^{clear_start, clear_colour};
   assign w_block    = 1'b0;
   assign w_clr_load = 1'b0;
   assign w_clr_data = 32'h0;
   assign clear_busy = 1'b0;
   assign clear_done = 1'b0;
`endif

   assign req0_ready    = w_gnt0;
   assign req1_ready    = w_gnt1;
   assign avm_address   = 4'h0;
   assign avm_write     = r_or_valid;
   assign avm_writedata = r_or_data;
   assign drop_count    = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_vga_plot_sched.sv
// ============================================================================
// Module   : tb_vga_plot_sched
// Purpose  : Directed self-checking bench for vga_plot_sched. A second
//            instance with a 3-bit drop counter exercises saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_plot_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [7:0]  req0_x, req1_x, req0_colour, req1_colour;
   logic [6:0]  req0_y, req1_y;
   logic        clear_start;
   logic [7:0]  clear_colour;
   logic        clear_busy, clear_done;
   logic [3:0]  avm_address;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic        avm_waitrequest;
   logic [15:0] drop_count;

   logic        s_req0_valid, s_req0_ready, s_req1_ready;
   logic [7:0]  s_req0_x;
   logic        s_clear_busy, s_clear_done, s_avm_write;
   logic [3:0]  s_avm_address;
   logic [31:0] s_avm_writedata;
   logic [2:0]  s_drop_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vga_plot_sched #(.SCREEN_W(160), .SCREEN_H(120), .DROP_W(16)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x),
      .req0_y(req0_y), .req0_colour(req0_colour),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x),
      .req1_y(req1_y), .req1_colour(req1_colour),
      .clear_start(clear_start), .clear_colour(clear_colour),
      .clear_busy(clear_busy), .clear_done(clear_done),
      .avm_address(avm_address), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
      .drop_count(drop_count)
   );

   vga_plot_sched #(.SCREEN_W(160), .SCREEN_H(120), .DROP_W(3)) u_sat (
      .clk(clk), .reset(reset),
      .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_x(s_req0_x),
      .req0_y(7'd5), .req0_colour(8'h00),
      .req1_valid(1'b0), .req1_ready(s_req1_ready), .req1_x(8'h00),
      .req1_y(7'h00), .req1_colour(8'h00),
      .clear_start(1'b0), .clear_colour(8'h00),
      .clear_busy(s_clear_busy), .clear_done(s_clear_done),
      .avm_address(s_avm_address), .avm_write(s_avm_write),
      .avm_writedata(s_avm_writedata), .avm_waitrequest(1'b0),
      .drop_count(s_drop_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req0_x = 8'h0; req0_y = 7'h0; req0_colour = 8'h0;
      req1_valid = 1'b0; req1_x = 8'h0; req1_y = 7'h0; req1_colour = 8'h0;
      clear_start = 1'b0; clear_colour = 8'h0; avm_waitrequest = 1'b0;
      s_req0_valid = 1'b0; s_req0_x = 8'h0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      #2;
      checks++; if (avm_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", avm_write); end
      checks++; if (avm_writedata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 00000000", avm_writedata); end
      checks++; if (avm_address !== 4'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", avm_address); end
      checks++; if ({clear_busy, clear_done} !== 2'b00) begin errors++; $display("FAIL reset_clear: got busy/done %b want 00", {clear_busy, clear_done}); end
      checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL reset_drop: got %h want 0000", drop_count); end
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single();
      req0_valid = 1'b1; req0_x = 8'd5; req0_y = 7'd7; req0_colour = 8'hFF;
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready}); end
      checks++; if (avm_write !== 1'b0) begin errors++; $display("FAIL single_write_c0: got %b want 0", avm_write); end
      tick();
      req0_valid = 1'b0;
      checks++; if (avm_write !== 1'b1) begin errors++; $display("FAIL single_write_c1: got %b want 1", avm_write); end
      checks++; if (avm_writedata !== 32'h070500FF) begin errors++; $display("FAIL single_wdata: got %h want 070500ff", avm_writedata); end
      checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL single_drop: got %h want 0000", drop_count); end
      tick();
      checks++; if (avm_write !== 1'b0) begin errors++; $display("FAIL single_write_c2: got %b want 0", avm_write); end
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_data;
      do_reset();
      req0_valid = 1'b1; req0_x = 8'd1; req0_y = 7'd1; req0_colour = 8'hA0;
      req1_valid = 1'b1; req1_x = 8'd2; req1_y = 7'd2; req1_colour = 8'hB1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL rr_grant%0d: got ready0/1 %b", i, {req0_ready, req1_ready});
         end
         exp_data = (i % 2 == 0) ? 32'h010100A0 : 32'h020200B1;
         tick();
         checks++;
         if (avm_write !== 1'b1 || avm_writedata !== exp_data) begin
            errors++; $display("FAIL rr_data%0d: got write %b data %h want 1 %h", i, avm_write, avm_writedata, exp_data);
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      checks++; if (avm_write !== 1'b0) begin errors++; $display("FAIL rr_idle: got %b want 0", avm_write); end
   endtask

   task automatic test_drop();
      req1_valid = 1'b1; req1_x = 8'd160; req1_y = 7'd0; req1_colour = 8'h11;
      #1;
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL drop_x_ready: got %b want 1", req1_ready); end
      tick();
      req1_x = 8'd0; req1_y = 7'd120;
      checks++; if (avm_write !== 1'b0 || drop_count !== 16'd1) begin errors++; $display("FAIL drop_x: got write %b drop %0d want 0 1", avm_write, drop_count); end
      #1;
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL drop_y_ready: got %b want 1", req1_ready); end
      tick();
      req1_x = 8'd159; req1_y = 7'd119; req1_colour = 8'h22;
      checks++; if (avm_write !== 1'b0 || drop_count !== 16'd2) begin errors++; $display("FAIL drop_y: got write %b drop %0d want 0 2", avm_write, drop_count); end
      tick();
      req1_valid = 1'b0;
      checks++; if (avm_write !== 1'b1 || avm_writedata !== 32'h779F0022 || drop_count !== 16'd2) begin
         errors++; $display("FAIL edge_pixel: got write %b data %h drop %0d want 1 779f0022 2", avm_write, avm_writedata, drop_count);
      end
      tick();
      // Saturation on the 3-bit counter instance.
      s_req0_valid = 1'b1; s_req0_x = 8'd200;
      for (int i = 1; i <= 9; i++) begin
         tick();
         if (i == 6) begin
            checks++; if (s_drop_count !== 3'd6) begin errors++; $display("FAIL sat_pre: got %0d want 6", s_drop_count); end
         end
         if (i == 7 || i == 9) begin
            checks++; if (s_drop_count !== 3'd7) begin errors++; $display("FAIL sat_hold%0d: got %0d want 7", i, s_drop_count); end
         end
      end
      s_req0_valid = 1'b0;
      checks++; if (s_avm_write !== 1'b0) begin errors++; $display("FAIL sat_nowrite: got %b want 0", s_avm_write); end
   endtask

   task automatic test_stall();
      avm_waitrequest = 1'b1;
      req0_valid = 1'b1; req0_x = 8'd3; req0_y = 7'd3; req0_colour = 8'h10;
      #1;
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL stall_accept: got %b want 1", req0_ready); end
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_x = 8'd4; req1_y = 7'd4; req1_colour = 8'h20;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (avm_write !== 1'b1 || avm_writedata !== 32'h03030010 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL stall_hold%0d: got write %b data %h ready1 %b want 1 03030010 0", k, avm_write, avm_writedata, req1_ready);
         end
         tick();
      end
      avm_waitrequest = 1'b0;
      #1;
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %b want 1", req1_ready); end
      tick();
      req1_valid = 1'b0;
      checks++; if (avm_write !== 1'b1 || avm_writedata !== 32'h04040020) begin errors++; $display("FAIL stall_next: got %b %h want 1 04040020", avm_write, avm_writedata); end
      tick();
      checks++; if (avm_write !== 1'b0) begin errors++; $display("FAIL stall_idle: got %b want 0", avm_write); end
   endtask

   task automatic test_clear();
`ifdef VGA_SCHED_CLEAR_EN
      int cyc, writes, data_err, bad_ready, done_cnt, first_wr, last_acc, done_cyc;
      logic [31:0] last_data;
      logic [7:0]  ex_x;
      logic [6:0]  ex_y;
      logic        seen_done;
      cyc = 0; writes = 0; data_err = 0; bad_ready = 0; done_cnt = 0;
      first_wr = -1; last_acc = -1; done_cyc = -1; last_data = 32'h0;
      ex_x = 8'h0; ex_y = 7'h0; seen_done = 1'b0;
      avm_waitrequest = 1'b0;
      req0_valid = 1'b1; req0_x = 8'd1; req0_y = 7'd2; req0_colour = 8'h03;
      clear_start = 1'b1; clear_colour = 8'h00;
      #1;
      checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL clr_start_wins: got ready0 %b want 0", req0_ready); end
      tick();
      clear_start = 1'b0;
      cyc = 1;
      checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL clr_busy_rise: got %b want 1", clear_busy); end
      while (!seen_done && cyc < 40000) begin
         avm_waitrequest = ($urandom_range(0, 3) == 0);
         #1;
         if (clear_busy && (req0_ready || req1_ready)) bad_ready++;
         if (avm_write && first_wr < 0) first_wr = cyc;
         if (avm_write && !avm_waitrequest) begin
            if (avm_writedata !== {1'b0, ex_y, ex_x, 16'h0000}) data_err++;
            last_data = avm_writedata; last_acc = cyc; writes++;
            if (ex_x == 8'd159) begin ex_x = 8'd0; ex_y = ex_y + 7'd1; end
            else ex_x = ex_x + 8'd1;
         end
         if (clear_done) begin done_cnt++; done_cyc = cyc; seen_done = 1'b1; end
         tick();
         cyc++;
      end
      req0_valid = 1'b0;
      avm_waitrequest = 1'b0;
      checks++; if (seen_done !== 1'b1) begin errors++; $display("FAIL clr_timeout: no done pulse within %0d cycles", cyc); end
      checks++; if (writes != 19200) begin errors++; $display("FAIL clr_writes: got %0d want 19200", writes); end
      checks++; if (data_err != 0) begin errors++; $display("FAIL clr_order: got %0d bad words want 0", data_err); end
      checks++; if (last_data !== 32'h779F0000) begin errors++; $display("FAIL clr_last: got %h want 779f0000", last_data); end
      checks++; if (first_wr != 2) begin errors++; $display("FAIL clr_first: got cycle %0d want 2", first_wr); end
      checks++; if (done_cyc != last_acc + 1) begin errors++; $display("FAIL clr_done_time: got %0d want %0d", done_cyc, last_acc + 1); end
      checks++; if (bad_ready != 0) begin errors++; $display("FAIL clr_ready: got %0d ready cycles want 0", bad_ready); end
      #1;
      checks++; if (clear_busy !== 1'b0 || clear_done !== 1'b0) begin errors++; $display("FAIL clr_end: got busy/done %b want 00", {clear_busy, clear_done}); end
      tick();
      checks++; if (avm_write !== 1'b0 || clear_done !== 1'b0) begin errors++; $display("FAIL clr_quiet: got write/done %b want 00", {avm_write, clear_done}); end

      // Reset in the middle of a clear.
      clear_start = 1'b1; clear_colour = 8'h5A;
      tick();
      clear_start = 1'b0;
      writes = 0; cyc = 0;
      while (writes < 1000 && cyc < 5000) begin
         #1;
         if (avm_write && !avm_waitrequest) writes++;
         tick();
         cyc++;
      end
      checks++; if (writes != 1000 || avm_write !== 1'b1) begin errors++; $display("FAIL rst_mid_reach: got %0d writes, write %b want 1000 1", writes, avm_write); end
      reset = 1'b1;
      #1;
      checks++; if ({avm_write, clear_busy, clear_done} !== 3'b000) begin errors++; $display("FAIL rst_mid_drop: got write/busy/done %b want 000", {avm_write, clear_busy, clear_done}); end
      done_cnt = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (clear_done) done_cnt++;
      end
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (clear_done || clear_busy) done_cnt++;
      end
      checks++; if (done_cnt != 0) begin errors++; $display("FAIL rst_mid_nodone: got %0d active cycles want 0", done_cnt); end
      clear_start = 1'b1; clear_colour = 8'h33;
      tick();
      clear_start = 1'b0;
      checks++; if (clear_busy !== 1'b1 || avm_write !== 1'b0) begin errors++; $display("FAIL rst_restart_busy: got busy/write %b want 10", {clear_busy, avm_write}); end
      tick();
      checks++; if (avm_write !== 1'b1 || avm_writedata !== 32'h00000033) begin errors++; $display("FAIL rst_restart_px: got %b %h want 1 00000033", avm_write, avm_writedata); end
      do_reset();
`else
      avm_waitrequest = 1'b0;
      clear_start = 1'b1; clear_colour = 8'h44;
      req0_valid = 1'b1; req0_x = 8'd9; req0_y = 7'd9; req0_colour = 8'h01;
      #1;
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL noclr_ready: got %b want 1", req0_ready); end
      tick();
      clear_start = 1'b0; req0_valid = 1'b0;
      checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL noclr_busy: got %b want 0", clear_busy); end
      checks++; if (avm_write !== 1'b1 || avm_writedata !== 32'h09090001) begin errors++; $display("FAIL noclr_write: got %b %h want 1 09090001", avm_write, avm_writedata); end
      tick();
      checks++; if (clear_done !== 1'b0 || avm_write !== 1'b0) begin errors++; $display("FAIL noclr_done: got done/write %b want 00", {clear_done, avm_write}); end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_drop();
      test_stall();
      test_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
